rtclock_trigger_sched: RTL and testbench
========================================

# rtclock_trigger_sched

Time-triggered event scheduler that shares the rtclock time base among several requesters. Each requester posts an absolute target time (sec, nsec). A round-robin arbiter admits one request at a time into a single armed compare slot. When the running clock reaches the target, the block emits a one-cycle fire pulse tagged with the requester id and the actual capture time. It sits beside rtclock and consumes its `sec`/`nsec` outputs in the same clk domain.

## Interface
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ), requester id width
- clk  in  1  rtclock domain clock
- resetn  in  1  reset resetn, synchronous, active-low; clock clk
- sec  in  48  current seconds from rtclock
- nsec  in  30  current nanoseconds from rtclock (0..999_999_999)
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_sec  in  N_REQ*48  target seconds, requester i at [48*i +: 48]
- req_nsec  in  N_REQ*30  target nanoseconds, requester i at [30*i +: 30]
- abort  in  1  cancel armed event
- fire_valid  out  1  one-cycle event pulse
- fire_id  out  ID_W  requester index of fired event
- fire_late  out  1  target was already in the past when armed
- fire_err  out  1  target nsec out of range (≥ 1e9)
- fire_sec  out  48  sec sampled on hit cycle
- fire_nsec  out  30  nsec sampled on hit cycle
- busy  out  1  slot armed (state WAIT)

## Operation
- FSM states: IDLE, WAIT. Reset enters IDLE with rr pointer 0 and the slot empty.
- IDLE, winner selection: the winner is the first i with req_valid[i] set, searching from the rr pointer upward modulo N_REQ.
- IDLE, acceptance:
  - req_ready[winner] = 1 combinationally. The transfer is req_valid & req_ready.
  - On transfer: latch the target and id, set the rr pointer to winner+1 (mod N_REQ), go to WAIT, set the first flag.
- IDLE, out-of-range target: if the accepted req_nsec ≥ 1_000_000_000, stay in IDLE. The next cycle carries fire_valid=1, fire_err=1, fire_late=0, fire_sec/fire_nsec = current time.
- WAIT, hit condition: hit = {sec,nsec} ≥ {tgt_sec,tgt_nsec}, an unsigned 78-bit compare that is valid because nsec < 2^30.
- WAIT, on hit:
  - Register fire_valid=1, fire_id, fire_sec/fire_nsec = sec/nsec of the hit cycle.
  - fire_late = first flag & ({sec,nsec} > target).
  - Return to IDLE.
- WAIT, first flag: cleared after the first WAIT cycle.
- req_ready is all-zero in WAIT and during reset.
- abort in WAIT: return to IDLE with no fire. Abort wins over a simultaneous hit. abort in IDLE is ignored.
- Time discontinuities (pps load of sec_config, backward jumps): no special handling. The compare is re-evaluated every cycle, so a backward jump only delays the hit.
- Reset mid-WAIT: the armed event is discarded and no fire is produced.
- Requester obligations:
  - hold req_valid and the target stable until accepted;
  - deassert req_valid (or present a new target) the cycle after acceptance.

## Timing
- Reset values: fire_valid 0, fire_id 0, fire_late 0, fire_err 0, fire_sec 0, fire_nsec 0, busy 0, req_ready 0.
- Accept at cycle t puts the block in WAIT at t+1. busy=1 from t+1.
- Hit at cycle u gives fire_valid high at u+1 for exactly one cycle. IDLE at u+1 can accept a new request in the same cycle.
- A target already in the past fires at t+2 (accept t, hit t+1, pulse t+2). The maximum scheduling rate is one event per 2 cycles.
- The err path fires at t+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.

## Structure
- Shared package `rtclock_pkg`:
  - constants NSEC_MODULO=1_000_000_000, SEC_W=48, NSEC_W=30;
  - the state enum, so rtclock and this block agree on time widths.
- One sub-module, `rtclock_rr_arb`:
  - inputs: request vector and pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The FSM, target registers and comparator live in the top module.

## Test plan
- Single on-time request (nsec steps by 8): clock at 5 s / 999_999_992 ns, req0 target 6 s / 0 ns → fire_valid one cycle after nsec=0, sec=6; fire_id=0, late=0, fire_sec=6, fire_nsec=0.
- Late target: clock at 10 s / 500 ns, req2 target 10 s / 100 ns → fire at accept+2, fire_late=1, fire_id=2.
- Round-robin: req0..req3 all valid with past targets from reset → fire_id sequence 0,1,2,3; then req1 and req3 re-asserted → 1 granted before 3 (pointer=0 after 3).
- Abort: req1 target 1000 s armed, abort pulsed while clock < target, then the target time is reached → no fire_valid, busy drops the cycle after abort. Abort coinciding with the hit cycle also yields no fire.
- Invalid target: req3 nsec=1_000_000_000 → fire at t+1 with fire_err=1, fire_id=3, busy stays 0.
- Reset mid-WAIT: reset asserted for 1 cycle during WAIT → all outputs 0, no fire when the target later passes, next request is granted to index 0 first.

Source files
------------

// File: rtl/rtclock_pkg.sv
// rtl/rtclock_pkg.sv - shared rtclock time-base widths, constants and scheduler state type
package rtclock_pkg;

    localparam int unsigned SEC_W  = 48;
    localparam int unsigned NSEC_W = 30;

    // One second in nanoseconds; any nsec at or above this is not a valid time
    localparam logic [NSEC_W-1:0] NSEC_MODULO = 30'd1_000_000_000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rtclock_rr_arb.sv
// rtl/rtclock_rr_arb.sv - combinational round-robin arbiter, search starts at the pointer
module rtclock_rr_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);

    // One extra bit so ptr + offset can exceed N_REQ before wrapping
    localparam int            SUM_W  = ID_W + 1;
    localparam logic [ID_W:0] N_WIDE = SUM_W'(N_REQ);

    logic [ID_W:0] w_sum;
    logic          w_found;

    // First requester at or after the pointer, wrapping modulo N_REQ
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(k);
            if (w_sum >= N_WIDE) begin
                w_sum = w_sum - N_WIDE;
            end
            if (!w_found && i_req[w_sum[ID_W-1:0]]) begin
                w_found                    = 1'b1;
                o_grant[w_sum[ID_W-1:0]]   = 1'b1;
                o_idx                      = w_sum[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rtclock_trigger_sched.sv
// rtl/rtclock_trigger_sched.sv - time-triggered event scheduler sharing the rtclock time base
module rtclock_trigger_sched
    import rtclock_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [SEC_W-1:0]          sec,
    input  logic [NSEC_W-1:0]         nsec,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*SEC_W-1:0]    req_sec,
    input  logic [N_REQ*NSEC_W-1:0]   req_nsec,
    input  logic                      abort,
    output logic                      fire_valid,
    output logic [ID_W-1:0]           fire_id,
    output logic                      fire_late,
    output logic                      fire_err,
    output logic [SEC_W-1:0]          fire_sec,
    output logic [NSEC_W-1:0]         fire_nsec,
    output logic                      busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    sched_state_e       r_state;
    sched_state_e       w_next_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_next;
    logic [SEC_W-1:0]   r_tgt_sec;
    logic [NSEC_W-1:0]  r_tgt_nsec;
    logic [ID_W-1:0]    r_id;
    logic               r_first;

    logic               r_fire_valid;
    logic [ID_W-1:0]    r_fire_id;
    logic               r_fire_late;
    logic               r_fire_err;
    logic [SEC_W-1:0]   r_fire_sec;
    logic [NSEC_W-1:0]  r_fire_nsec;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_idx;
    logic [SEC_W-1:0]   w_req_sec_a  [N_REQ];
    logic [NSEC_W-1:0]  w_req_nsec_a [N_REQ];
    logic [SEC_W-1:0]   w_sel_sec;
    logic [NSEC_W-1:0]  w_sel_nsec;
    logic               w_nsec_bad;
    logic               w_hit;
    logic               w_past;
    logic               w_accept;
    logic               w_fire_hit;
    logic               w_fire_err;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_req_sec_a[g]  = req_sec[g*SEC_W +: SEC_W];
        assign w_req_nsec_a[g] = req_nsec[g*NSEC_W +: NSEC_W];
    end

    rtclock_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_sel_sec  = w_req_sec_a[w_idx];
    assign w_sel_nsec = w_req_nsec_a[w_idx];
    assign w_nsec_bad = (w_sel_nsec >= NSEC_MODULO);
    assign w_ptr_next = (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;

    // nsec never reaches 2^30, so {sec,nsec} orders like a flat time value
    assign w_hit  = ({sec, nsec} >= {r_tgt_sec, r_tgt_nsec});
    assign w_past = ({sec, nsec} >  {r_tgt_sec, r_tgt_nsec});

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, acceptance handshake and fire decisions
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fire_hit   = 1'b0;
        w_fire_err   = 1'b0;
        req_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (resetn && (|w_grant)) begin
                    req_ready = w_grant;
                    w_accept  = 1'b1;
                    if (w_nsec_bad) begin
                        w_fire_err = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Abort takes priority over a hit in the same cycle
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_hit) begin
                    w_fire_hit   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Armed-slot contents and round-robin pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr      <= '0;
            r_tgt_sec  <= '0;
            r_tgt_nsec <= '0;
            r_id       <= '0;
            r_first    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr      <= w_ptr_next;
                r_tgt_sec  <= w_sel_sec;
                r_tgt_nsec <= w_sel_nsec;
                r_id       <= w_idx;
                r_first    <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_first <= 1'b0;
            end
        end
    end

    // Registered fire pulse; tag fields hold until the next event
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fire_valid <= 1'b0;
            r_fire_id    <= '0;
            r_fire_late  <= 1'b0;
            r_fire_err   <= 1'b0;
            r_fire_sec   <= '0;
            r_fire_nsec  <= '0;
        end else begin
            r_fire_valid <= w_fire_hit | w_fire_err;
            if (w_fire_err) begin
                r_fire_id   <= w_idx;
                r_fire_late <= 1'b0;
                r_fire_err  <= 1'b1;
                r_fire_sec  <= sec;
                r_fire_nsec <= nsec;
            end else if (w_fire_hit) begin
                r_fire_id   <= r_id;
                r_fire_late <= r_first & w_past;
                r_fire_err  <= 1'b0;
                r_fire_sec  <= sec;
                r_fire_nsec <= nsec;
            end
        end
    end

    assign fire_valid = r_fire_valid;
    assign fire_id    = r_fire_id;
    assign fire_late  = r_fire_late;
    assign fire_err   = r_fire_err;
    assign fire_sec   = r_fire_sec;
    assign fire_nsec  = r_fire_nsec;
    assign busy       = (r_state == ST_WAIT);

endmodule

// File: tb/tb_rtclock_trigger_sched.sv
// tb/tb_rtclock_trigger_sched.sv - self-checking bench for rtclock_trigger_sched
module tb_rtclock_trigger_sched;

    localparam int              N      = 4;
    localparam int              IW     = 2;
    localparam longint unsigned NS     = 64'd1_000_000_000;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  id;
        logic        late;
        logic        err;
        logic [47:0] s;
        logic [29:0] ns;
    } ev_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [47:0]       sec;
    logic [29:0]       nsec;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*48-1:0]   req_sec;
    logic [N*30-1:0]   req_nsec;
    logic              abort;
    logic              fire_valid;
    logic [IW-1:0]     fire_id;
    logic              fire_late;
    logic              fire_err;
    logic [47:0]       fire_sec;
    logic [29:0]       fire_nsec;
    logic              busy;

    always #5 clk = ~clk;

    rtclock_trigger_sched #(.N_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sec        (sec),
        .nsec       (nsec),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sec    (req_sec),
        .req_nsec   (req_nsec),
        .abort      (abort),
        .fire_valid (fire_valid),
        .fire_id    (fire_id),
        .fire_late  (fire_late),
        .fire_err   (fire_err),
        .fire_sec   (fire_sec),
        .fire_nsec  (fire_nsec),
        .busy       (busy)
    );

    // requesters and time source
    bit              rv [N];
    longint unsigned rs [N];
    longint unsigned rn [N];
    longint unsigned t_sec, t_nsec, step;
    int              cyc;

    // reference model: one armed slot holding a flat nanosecond target
    bit              m_wait, m_first;
    int              m_ptr, m_id;
    longint unsigned m_tgt;

    ev_t             obs_q[$];
    ev_t             exp_q[$];
    int              ready_bad, busy_bad;
    logic [N-1:0]    rb_act, rb_exp;

    int              tests, fails;

    task automatic drive();
        sec  = t_sec[47:0];
        nsec = t_nsec[29:0];
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = rv[i];
            req_sec[48*i +: 48]   = rs[i][47:0];
            req_nsec[30*i +: 30]  = rn[i][29:0];
        end
    endtask

    task automatic clear_log();
        obs_q.delete();
        exp_q.delete();
        ready_bad = 0;
        busy_bad  = 0;
    endtask

    task automatic set_time(input longint unsigned s, input longint unsigned n, input longint unsigned st);
        t_sec  = s;
        t_nsec = n;
        step   = st;
    endtask

    // One clock: model predicts grant/fire, DUT observations are logged
    task automatic step_cycle();
        int              g;
        logic [N-1:0]    er;
        longint unsigned now;
        bit              e_fire;
        ev_t             e, o;
        drive();
        @(negedge clk);
        g = -1;
        if (resetn && !m_wait) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        if (req_ready !== er) begin
            if (ready_bad == 0) begin rb_act = req_ready; rb_exp = er; end
            ready_bad++;
        end
        now    = t_sec * NS + t_nsec;
        e_fire = 1'b0;
        e      = '0;
        e.cyc  = 32'(cyc + 1);
        e.s    = t_sec[47:0];
        e.ns   = t_nsec[29:0];
        if (!resetn) begin
            m_wait = 1'b0; m_first = 1'b0; m_ptr = 0;
        end else if (!m_wait) begin
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (rn[g] >= NS) begin
                    e_fire = 1'b1; e.id = 4'(g); e.err = 1'b1; e.late = 1'b0;
                end else begin
                    m_wait = 1'b1; m_first = 1'b1; m_id = g;
                    m_tgt  = rs[g] * NS + rn[g];
                end
                rv[g] = 1'b0;
            end
        end else begin
            if (abort) begin
                m_wait = 1'b0;
            end else if (now >= m_tgt) begin
                e_fire = 1'b1; e.id = 4'(m_id); e.err = 1'b0;
                e.late = m_first && (now > m_tgt);
                m_wait = 1'b0;
            end
            m_first = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (e_fire) exp_q.push_back(e);
        if (fire_valid !== 1'b0) begin
            o      = '0;
            o.cyc  = 32'(cyc);
            o.id   = 4'(fire_id);
            o.late = fire_late;
            o.err  = fire_err;
            o.s    = fire_sec;
            o.ns   = fire_nsec;
            obs_q.push_back(o);
        end
        if (busy !== m_wait) busy_bad++;
        abort  = 1'b0;
        t_nsec = t_nsec + step;
        if (t_nsec >= NS) begin t_nsec = t_nsec - NS; t_sec++; end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < N; i++) begin rv[i] = 1'b1; rs[i] = 0; rn[i] = 0; end
        clear_log();
        step_cycle();
        step_cycle();
        tests++;
        if (req_ready !== '0) begin
            fails++; $display("FAIL reset_ready actual=%b required=0", req_ready);
        end
        tests++;
        if ({fire_valid, fire_late, fire_err, busy} !== 4'b0) begin
            fails++; $display("FAIL reset_flags actual=%b required=0000", {fire_valid, fire_late, fire_err, busy});
        end
        tests++;
        if ({fire_id, fire_sec, fire_nsec} !== '0) begin
            fails++; $display("FAIL reset_tag actual id=%0d sec=%0d nsec=%0d required=0", fire_id, fire_sec, fire_nsec);
        end
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        resetn = 1'b1;
        step_cycle();
        tests++;
        if (ready_bad !== 0 || obs_q.size() !== 0) begin
            fails++; $display("FAIL reset_quiet actual ready_bad=%0d events=%0d required=0", ready_bad, obs_q.size());
        end
    endtask

    task automatic test_on_time();
        clear_log();
        set_time(5, 999_999_992, 8);
        rv[0] = 1'b1; rs[0] = 6; rn[0] = 0;
        for (int k = 0; k < 6; k++) step_cycle();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL ontime_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL ontime_event%0d actual=%h required=%h", k, obs_q[k], exp_q[k]);
            end
        end
        tests++;
        if (obs_q.size() !== 1 || obs_q[0].s !== 48'd6 || obs_q[0].ns !== 30'd0 ||
            obs_q[0].id !== 4'd0 || obs_q[0].late !== 1'b0) begin
            fails++; $display("FAIL ontime_values actual=%h required sec=6 nsec=0 id=0 late=0", obs_q[0]);
        end
        tests++;
        if (ready_bad !== 0 || busy_bad !== 0) begin
            fails++; $display("FAIL ontime_hs actual ready=%b busy_bad=%0d required ready=%b busy_bad=0", rb_act, busy_bad, rb_exp);
        end
    endtask

    task automatic test_late();
        int start;
        clear_log();
        set_time(10, 500, 8);
        rv[2] = 1'b1; rs[2] = 10; rn[2] = 100;
        start = cyc;
        for (int k = 0; k < 5; k++) step_cycle();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL late_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL late_event%0d actual=%h required=%h", k, obs_q[k], exp_q[k]);
            end
        end
        tests++;
        if (obs_q.size() !== 1 || obs_q[0].cyc !== 32'(start + 2) ||
            obs_q[0].id !== 4'd2 || obs_q[0].late !== 1'b1) begin
            fails++; $display("FAIL late_values actual=%h required cyc=%0d id=2 late=1", obs_q[0], start + 2);
        end
    endtask

    task automatic test_round_robin();
        int ids [6];
        ids = '{0, 1, 2, 3, 1, 3};
        resetn = 1'b0;
        step_cycle();
        resetn = 1'b1;
        clear_log();
        set_time(100, 0, 8);
        for (int i = 0; i < N; i++) begin rv[i] = 1'b1; rs[i] = 50; rn[i] = longint'(i); end
        for (int k = 0; k < 10; k++) step_cycle();
        rv[3] = 1'b1; rv[1] = 1'b1;
        for (int k = 0; k < 6; k++) step_cycle();
        tests++;
        if (obs_q.size() !== 6) begin
            fails++; $display("FAIL rr_count actual=%0d required=6", obs_q.size());
        end
        for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
            tests++;
            if (obs_q[k].id !== 4'(ids[k])) begin
                fails++; $display("FAIL rr_order%0d actual=%0d required=%0d", k, obs_q[k].id, ids[k]);
            end
        end
        tests++;
        if (ready_bad !== 0 || busy_bad !== 0) begin
            fails++; $display("FAIL rr_hs actual ready=%b busy_bad=%0d required ready=%b busy_bad=0", rb_act, busy_bad, rb_exp);
        end
    endtask

    task automatic test_abort();
        clear_log();
        set_time(999, 999_999_000, 8);
        rv[1] = 1'b1; rs[1] = 1000; rn[1] = 0;
        step_cycle();
        step_cycle();
        abort = 1'b1;
        step_cycle();
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL abort_busy actual=%b required=0", busy);
        end
        set_time(1000, 0, 8);
        for (int k = 0; k < 4; k++) step_cycle();
        set_time(1999, 999_999_992, 8);
        rv[0] = 1'b1; rs[0] = 2000; rn[0] = 0;
        step_cycle();
        abort = 1'b1;
        for (int k = 0; k < 4; k++) step_cycle();
        tests++;
        if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL abort_nofire actual=%0d events required=0 (model %0d)", obs_q.size(), exp_q.size());
        end
        tests++;
        if (ready_bad !== 0 || busy_bad !== 0) begin
            fails++; $display("FAIL abort_hs actual ready=%b busy_bad=%0d required ready=%b busy_bad=0", rb_act, busy_bad, rb_exp);
        end
    endtask

    task automatic test_invalid();
        clear_log();
        set_time(20, 40, 8);
        rv[3] = 1'b1; rs[3] = 20; rn[3] = NS;
        step_cycle();
        tests++;
        if ({fire_valid, fire_err, fire_late, busy} !== 4'b1100 || fire_id !== 2'd3) begin
            fails++; $display("FAIL invalid_pulse actual v/e/l/b=%b id=%0d required=1100 id=3",
                              {fire_valid, fire_err, fire_late, busy}, fire_id);
        end
        for (int k = 0; k < 3; k++) step_cycle();
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL invalid_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL invalid_event%0d actual=%h required=%h", k, obs_q[k], exp_q[k]);
            end
        end
        tests++;
        if (busy_bad !== 0) begin
            fails++; $display("FAIL invalid_busy actual busy_bad=%0d required=0", busy_bad);
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_log();
        set_time(300, 0, 8);
        rv[0] = 1'b1; rs[0] = 300; rn[0] = 800;
        step_cycle();
        step_cycle();
        resetn = 1'b0;
        step_cycle();
        tests++;
        if ({fire_valid, fire_late, fire_err, busy, fire_id, fire_sec, fire_nsec} !== '0) begin
            fails++; $display("FAIL midreset_outputs actual v=%b b=%b id=%0d sec=%0d nsec=%0d required=0",
                              fire_valid, busy, fire_id, fire_sec, fire_nsec);
        end
        resetn = 1'b1;
        for (int k = 0; k < 120; k++) step_cycle();
        tests++;
        if (obs_q.size() !== 0) begin
            fails++; $display("FAIL midreset_nofire actual=%0d required=0", obs_q.size());
        end
        rv[2] = 1'b1; rs[2] = 1; rn[2] = 0;
        rv[0] = 1'b1; rs[0] = 1; rn[0] = 0;
        for (int k = 0; k < 6; k++) step_cycle();
        tests++;
        if (obs_q.size() !== 2 || obs_q[0].id !== 4'd0 || obs_q[1].id !== 4'd2) begin
            fails++; $display("FAIL midreset_order actual n=%0d ids=%0d,%0d required n=2 ids=0,2",
                              obs_q.size(), obs_q[0].id, obs_q[1].id);
        end
    endtask

    task automatic test_random();
        longint unsigned now, tg;
        int              off;
        clear_log();
        set_time(7, 999_990_000, 8);
        for (int c = 0; c < 3000; c++) begin
            now = t_sec * NS + t_nsec;
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 7) == 0) begin
                    off = int'($urandom_range(0, 400)) - 150;
                    tg  = longint'(now) + off;
                    rv[i] = 1'b1;
                    rs[i] = tg / NS;
                    rn[i] = tg % NS;
                    if ($urandom_range(0, 15) == 0) rn[i] = NS + $urandom_range(0, 1000);
                end
            end
            if ($urandom_range(0, 39) == 0) abort = 1'b1;
            step = $urandom_range(1, 20);
            if ($urandom_range(0, 199) == 0 && t_nsec >= 1000) t_nsec = t_nsec - 500;
            step_cycle();
        end
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL random_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++; $display("FAIL random_event%0d actual=%h required=%h", k, obs_q[k], exp_q[k]);
            end
        end
        tests++;
        if (ready_bad !== 0 || busy_bad !== 0) begin
            fails++; $display("FAIL random_hs actual ready=%b busy_bad=%0d ready_bad=%0d required ready=%b 0 0",
                              rb_act, busy_bad, ready_bad, rb_exp);
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        resetn = 1'b0; abort = 1'b0;
        m_wait = 1'b0; m_first = 1'b0; m_ptr = 0; m_id = 0; m_tgt = 0;
        rb_act = '0; rb_exp = '0;
        set_time(0, 0, 8);
        for (int i = 0; i < N; i++) begin rv[i] = 1'b0; rs[i] = 0; rn[i] = 0; end
        drive();
        test_reset();
        test_on_time();
        test_late();
        test_round_robin();
        test_abort();
        test_invalid();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
